// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  function automatic int unsigned lanes(input int unsigned width, input int unsigned en_gran);
    return width / en_gran;
  endfunction

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Sequential clear engine: walks the array from entry 0 to DEPTH-1 writing zeros.
module reg_file_clr_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned DEPTH        = 24,
  parameter int unsigned DEPTH_BITS   = 5,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_en,
  output logic                  busy,
  output logic                  clr_we,
  output logic [DEPTH_BITS-1:0] clr_addr,
  output logic                  block
);

  localparam logic [DEPTH_BITS-1:0] LP_LAST      = DEPTH_BITS'(DEPTH - 1);
  localparam clr_state_t            LP_RST_STATE = (CLR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;

  clr_state_t            r_state, w_state_nxt;
  logic [DEPTH_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                  r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LP_RST_STATE;
      r_cnt   <= '0;
      r_busy  <= (CLR_ON_RESET != 0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == CLR_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      CLR_IDLE: begin
        if (!clr_en) begin
          w_state_nxt = CLR_RUN;
          w_cnt_nxt   = '0;
        end
      end
      CLR_RUN: begin
        if (r_cnt == LP_LAST) begin
          w_state_nxt = CLR_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  // The accepting cycle is blocked too, so the request never races an external write.
  always_comb begin
    busy     = r_busy;
    clr_we   = (r_state == CLR_RUN);
    clr_addr = r_cnt;
    block    = (r_state == CLR_RUN) || ((r_state == CLR_IDLE) && !clr_en);
  end

endmodule

// File: rtl/reg_file_mp.sv
// Flip-flop register file: one lane-masked write port, NUM_RD registered read ports with
// write-first bypass, and a sequential clear engine.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 24,
  parameter int unsigned DEPTH_BITS   = 5,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned EN_GRAN      = 1,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DEPTH_BITS-1:0]        wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [WIDTH-1:0]             wr_bit_en,
  input  logic                         wr_en,
  input  logic [NUM_RD*DEPTH_BITS-1:0] rd_addr,
  input  logic [NUM_RD-1:0]            rd_en,
  output logic [NUM_RD*WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         clr_en,
  output logic                         busy
);

  localparam int unsigned LP_LANES = lanes(WIDTH, EN_GRAN);

  if (WIDTH % EN_GRAN != 0) begin : g_bad_gran
    $error("WIDTH must be a multiple of EN_GRAN");
  end
  if (DEPTH > (32'd1 << DEPTH_BITS)) begin : g_bad_depth
    $error("DEPTH does not fit in DEPTH_BITS");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("NUM_RD must be 1..4");
  end

  logic                  w_clr_we;
  logic [DEPTH_BITS-1:0] w_clr_addr;
  logic                  w_block;

  reg_file_clr_ctrl #(
    .DEPTH        (DEPTH),
    .DEPTH_BITS   (DEPTH_BITS),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (clr_en),
    .busy     (busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .block    (w_block)
  );

  logic [WIDTH-1:0] r_mem [DEPTH];

  // A lane is written only when every mask bit inside it is low.
  logic [LP_LANES-1:0] w_lane_we;
  logic [WIDTH-1:0]    w_bit_we;

  for (genvar k = 0; k < LP_LANES; k++) begin : g_lane
    assign w_lane_we[k] = ~wr_en & ~(|wr_bit_en[k*EN_GRAN +: EN_GRAN]);
    assign w_bit_we[k*EN_GRAN +: EN_GRAN] = {EN_GRAN{w_lane_we[k]}};
  end

  logic             w_wr_in_range;
  logic             w_ext_we;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_wr_merged;

  assign w_wr_in_range = (32'(wr_addr) < DEPTH);
  assign w_ext_we      = ~wr_en & ~w_block & w_wr_in_range;
  assign w_wr_old      = w_wr_in_range ? r_mem[wr_addr] : '0;
  assign w_wr_merged   = (w_wr_old & ~w_bit_we) | (wr_data & w_bit_we);

  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (w_clr_we && (w_clr_addr == DEPTH_BITS'(e))) begin
        r_mem[e] <= '0;
      end else if (w_ext_we && (wr_addr == DEPTH_BITS'(e))) begin
        r_mem[e] <= w_wr_merged;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DEPTH_BITS-1:0] w_raddr;
    logic [WIDTH-1:0]      w_rdata_nxt;
    logic                  w_rvalid_nxt;
    logic [WIDTH-1:0]      r_data;
    logic                  r_valid;

    assign w_raddr = rd_addr[p*DEPTH_BITS +: DEPTH_BITS];

    // Out-of-range reads are still acknowledged, with zero data.
    always_comb begin
      w_rdata_nxt  = '0;
      w_rvalid_nxt = 1'b0;
      if (!w_block && !rd_en[p]) begin
        w_rvalid_nxt = 1'b1;
        if (32'(w_raddr) < DEPTH) begin
          if (w_ext_we && (wr_addr == w_raddr)) begin
            w_rdata_nxt = w_wr_merged;
          end else begin
            w_rdata_nxt = r_mem[w_raddr];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_data  <= w_rdata_nxt;
        r_valid <= w_rvalid_nxt;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = r_data;
    assign rd_valid[p]               = r_valid;
  end

endmodule
